// File: rtl/alu_serial.sv
// Nibble-serial ALU (add/adc/sub/sbc/cp/and/xor/or; decimal adjust under ALU_SERIAL_DAA_EN), WIDTH/4 RUN cycles then a one-cycle done.
// Latency: done follows the start edge by WIDTH/4 edges; start is ignored while busy or done, nothing is queued.
module alu_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             in_C,
    input  logic             in_N,
    input  logic             in_H,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             out_Z,
    output logic             out_N,
    output logic             out_H,
    output logic             out_C
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_CP  = 4'd7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_q;
    logic             cy;
    logic             h_q;
    logic             nz_q;
    logic             n_in_q;
    logic             c_daa_q;

    logic             start_daa;
    logic             run_daa;
    logic             daa_hi;
    logic [WIDTH-1:0] daa_corr;

`ifdef ALU_SERIAL_DAA_EN
    localparam logic [3:0] OP_DAA = 4'd8;
    logic daa_lo;

    // Decimal adjust is run as A +/- correction on the same nibble adder.
    assign start_daa = (alu_op == OP_DAA);
    assign run_daa   = (op_q == OP_DAA);
    assign daa_lo    = in_N ? in_H : (in_H || (in_A[3:0] > 4'd9));
    assign daa_hi    = in_N ? in_C : (in_C || (in_A > WIDTH'(8'h99)));
    assign daa_corr  = WIDTH'({(daa_hi ? 4'h6 : 4'h0), (daa_lo ? 4'h6 : 4'h0)});
`else
    logic unused_daa;

    assign start_daa  = 1'b0;
    assign run_daa    = 1'b0;
    assign daa_hi     = 1'b0;
    assign daa_corr   = '0;
    assign unused_daa = in_H;
`endif

    logic             cy_init;
    logic             sub_op;
    logic             arith_op;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       sum;
    logic [3:0]       nib;
    logic [WIDTH-1:0] res_next;
    logic             h_fin;
    logic             fl_n;
    logic             fl_h;
    logic             fl_c;

    always_comb begin
        cy_init = 1'b0;
        case (alu_op)
            OP_ADC:        cy_init = in_C;
            OP_SUB, OP_CP: cy_init = 1'b1;
            OP_SBC:        cy_init = !in_C;
            default:       cy_init = start_daa ? in_N : 1'b0;
        endcase
    end

    always_comb begin
        a_nib    = a_sh[3:0];
        sub_op   = (op_q inside {OP_SUB, OP_SBC, OP_CP}) || (run_daa && n_in_q);
        arith_op = (op_q inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP}) || run_daa;
        b_nib    = sub_op ? ~b_sh[3:0] : b_sh[3:0];
        sum      = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, cy};
        case (op_q)
            OP_AND:  nib = a_nib & b_sh[3:0];
            OP_XOR:  nib = a_nib ^ b_sh[3:0];
            OP_OR:   nib = a_nib | b_sh[3:0];
            default: nib = arith_op ? sum[3:0] : a_nib;
        endcase
        res_next = res_q;
        res_next[{idx, 2'b00} +: 4] = nib;
        // With a single nibble the half-carry is the carry being produced right now.
        h_fin = (idx == '0) ? sum[4] : h_q;
    end

    always_comb begin
        fl_n = 1'b0;
        fl_h = 1'b0;
        fl_c = 1'b0;
        if (run_daa) begin
            fl_n = n_in_q;
            fl_c = c_daa_q;
        end else begin
            case (op_q)
                OP_ADD, OP_ADC: begin
                    fl_h = h_fin;
                    fl_c = sum[4];
                end
                OP_SUB, OP_SBC, OP_CP: begin
                    fl_n = 1'b1;
                    fl_h = !h_fin;
                    fl_c = !sum[4];
                end
                OP_AND:  fl_h = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            out     <= '0;
            out_Z   <= 1'b0;
            out_N   <= 1'b0;
            out_H   <= 1'b0;
            out_C   <= 1'b0;
            idx     <= '0;
            op_q    <= '0;
            a_q     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            res_q   <= '0;
            cy      <= 1'b0;
            h_q     <= 1'b0;
            nz_q    <= 1'b0;
            n_in_q  <= 1'b0;
            c_daa_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        idx     <= '0;
                        op_q    <= alu_op;
                        a_q     <= in_A;
                        a_sh    <= in_A;
                        b_sh    <= start_daa ? daa_corr : in_B;
                        res_q   <= '0;
                        cy      <= cy_init;
                        nz_q    <= 1'b0;
                        n_in_q  <= in_N;
                        c_daa_q <= daa_hi;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    res_q <= res_next;
                    cy    <= sum[4];
                    nz_q  <= nz_q | (|nib);
                    idx   <= idx + 1'b1;
                    if (idx == '0) begin
                        h_q <= sum[4];
                    end
                    if (idx == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        out   <= (op_q == OP_CP) ? a_q : res_next;
                        out_Z <= !(nz_q | (|nib));
                        out_N <= fl_n;
                        out_H <= fl_h;
                        out_C <= fl_c;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial (WIDTH=8): directed vectors, randomized ops against an arithmetic model, handshake and reset.
module tb_alu_serial;

    localparam int W   = 8;
    localparam int NIB = W / 4;

`ifdef ALU_SERIAL_DAA_EN
    localparam bit DAA_EN = 1'b1;
`else
    localparam bit DAA_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   alu_op;
    logic [W-1:0] in_A;
    logic [W-1:0] in_B;
    logic         in_C;
    logic         in_N;
    logic         in_H;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         out_Z;
    logic         out_N;
    logic         out_H;
    logic         out_C;

    int compared   = 0;
    int mismatched = 0;

    alu_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .alu_op (alu_op),
        .in_A   (in_A),
        .in_B   (in_B),
        .in_C   (in_C),
        .in_N   (in_N),
        .in_H   (in_H),
        .busy   (busy),
        .done   (done),
        .out    (out),
        .out_Z  (out_Z),
        .out_N  (out_N),
        .out_H  (out_H),
        .out_C  (out_C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {out, Z, N, H, C} computed with whole-word integer arithmetic.
    function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic ni, input logic hi);
        int ia;
        int ib;
        int r;
        int cin;
        int corr;
        logic hic;
        logic z;
        logic n;
        logic h;
        logic c;
        logic [W-1:0] o;
        ia = int'(a);
        ib = int'(b);
        r  = ia;
        n  = 1'b0;
        h  = 1'b0;
        c  = 1'b0;
        case (op)
            4'd0, 4'd1: begin
                cin = (op == 4'd1) ? int'(ci) : 0;
                r   = ia + ib + cin;
                c   = (r >= (1 << W));
                h   = ((ia % 16) + (ib % 16) + cin) > 15;
            end
            4'd2, 4'd3, 4'd7: begin
                cin = (op == 4'd3) ? int'(ci) : 0;
                r   = ia - ib - cin;
                c   = (r < 0);
                h   = ((ia % 16) - (ib % 16) - cin) < 0;
                n   = 1'b1;
            end
            4'd4: begin
                r = ia & ib;
                h = 1'b1;
            end
            4'd5: r = ia ^ ib;
            4'd6: r = ia | ib;
            4'd8: begin
                if (DAA_EN) begin
                    corr = 0;
                    if (ni) begin
                        if (hi) corr = corr + 6;
                        hic = ci;
                    end else begin
                        if (hi || (ia % 16) > 9) corr = corr + 6;
                        hic = ci || (ia > 'h99);
                    end
                    if (hic) corr = corr + 'h60;
                    r = ni ? (ia - corr) : (ia + corr);
                    c = hic;
                    n = ni;
                end
            end
            default: r = ia;
        endcase
        o = r[W-1:0];
        z = (o == '0);
        if (op == 4'd7) o = a;
        return {o, z, n, h, c};
    endfunction

    // Issues one op with minimum spacing; reports edges from start to done, busy behaviour and the results.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic n, input logic h,
                          output int lat, output logic busy_ok, output logic [W+3:0] got);
        @(posedge clk);
        #1;
        alu_op = op;
        in_A   = a;
        in_B   = b;
        in_C   = c;
        in_N   = n;
        in_H   = h;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        alu_op  = 4'($urandom);
        in_A    = W'($urandom);
        in_B    = W'($urandom);
        in_C    = 1'($urandom);
        in_N    = 1'($urandom);
        in_H    = 1'($urandom);
        lat     = 0;
        busy_ok = busy && !done;
        while (!done && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (!done && !busy) busy_ok = 1'b0;
        end
        if (done && busy) busy_ok = 1'b0;
        got = {out, out_Z, out_N, out_H, out_C};
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b1;
        alu_op = 4'd0;
        in_A   = 8'h55;
        in_B   = 8'hAA;
        in_C   = 1'b1;
        in_N   = 1'b0;
        in_H   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_handshake: busy=%b done=%b, want 0 0", busy, done);
        end
        compared++;
        if ({out, out_Z, out_N, out_H, out_C} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: out=%h ZNHC=%b%b%b%b, want 00 0000", out, out_Z, out_N, out_H, out_C);
        end
        rst   = 1'b0;
        start = 1'b0;
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         n;
        logic         h;
        logic [W-1:0] eo;
        logic [3:0]   ef;
    } vec_t;

    task automatic test_directed();
        vec_t tv[$];
        int lat;
        logic bok;
        logic [W+3:0] got;
        tv.push_back('{4'd0, 8'h0F, 8'h01, 1'b1, 1'b0, 1'b0, 8'h10, 4'b0010});
        tv.push_back('{4'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 4'b1011});
        tv.push_back('{4'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 4'b0000});
        tv.push_back('{4'd2, 8'h10, 8'h01, 1'b0, 1'b0, 1'b0, 8'h0F, 4'b0110});
        tv.push_back('{4'd3, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFF, 4'b0111});
        tv.push_back('{4'd7, 8'h42, 8'h42, 1'b0, 1'b0, 1'b0, 8'h42, 4'b1100});
        tv.push_back('{4'd4, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h00, 4'b1010});
        tv.push_back('{4'd5, 8'hA5, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h5A, 4'b0000});
        tv.push_back('{4'd6, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'b1000});
        tv.push_back('{4'd12, 8'h00, 8'h77, 1'b1, 1'b1, 1'b1, 8'h00, 4'b1000});
        tv.push_back('{4'd0, 8'h15, 8'h27, 1'b0, 1'b0, 1'b0, 8'h3C, 4'b0000});
        tv.push_back('{4'd8, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, DAA_EN ? 8'h42 : 8'h3C, 4'b0000});
        tv.push_back('{4'd8, 8'h9A, 8'h00, 1'b0, 1'b0, 1'b0, DAA_EN ? 8'h00 : 8'h9A, DAA_EN ? 4'b1001 : 4'b0000});
        foreach (tv[i]) begin
            run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].c, tv[i].n, tv[i].h, lat, bok, got);
            compared++;
            if (lat != NIB || bok !== 1'b1) begin
                mismatched++;
                $display("FAIL directed_timing[%0d]: done after %0d edges busy_ok=%b, want %0d 1", i, lat, bok, NIB);
            end
            compared++;
            if (got !== {tv[i].eo, tv[i].ef}) begin
                mismatched++;
                $display("FAIL directed_result[%0d] op=%0d: out=%h ZNHC=%b, want %h %b",
                         i, tv[i].op, got[W+3:4], got[3:0], tv[i].eo, tv[i].ef);
            end
        end
    endtask

    task automatic test_random(input int count, input string tag);
        int lat;
        logic bok;
        logic [W+3:0] got;
        logic [W+3:0] exp;
        logic [3:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic c;
        logic n;
        logic h;
        for (int i = 0; i < count; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = W'($urandom);
            b  = W'($urandom);
            if (i % 5 == 0) a = (i % 10 == 0) ? 8'h00 : 8'hFF;
            if (i % 7 == 0) b = a;
            c = 1'($urandom);
            n = 1'($urandom);
            h = 1'($urandom);
            exp = model(op, a, b, c, n, h);
            run_op(op, a, b, c, n, h, lat, bok, got);
            compared++;
            if (lat != NIB || bok !== 1'b1 || got !== exp) begin
                mismatched++;
                $display("FAIL %s[%0d] op=%0d A=%h B=%h C=%b N=%b H=%b: out=%h ZNHC=%b lat=%0d busy_ok=%b, want %h %b lat=%0d",
                         tag, i, op, a, b, c, n, h, got[W+3:4], got[3:0], lat, bok, exp[W+3:4], exp[3:0], NIB);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_random(8, "back_to_back");
    endtask

    task automatic test_ignore_start();
        int lat;
        @(posedge clk);
        #1;
        alu_op = 4'd2;
        in_A   = 8'h10;
        in_B   = 8'h01;
        in_C   = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        alu_op = 4'd0;
        in_A   = 8'hFF;
        in_B   = 8'hFF;
        lat    = 0;
        while (!done && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        compared++;
        if (lat != NIB || {out, out_Z, out_N, out_H, out_C} !== {8'h0F, 4'b0110}) begin
            mismatched++;
            $display("FAIL ignore_start_result: lat=%0d out=%h ZNHC=%b%b%b%b, want %0d 0f 0110",
                     lat, out, out_Z, out_N, out_H, out_C, NIB);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            compared++;
            if (busy !== 1'b0 || done !== 1'b0 || out !== 8'h0F || out_N !== 1'b1) begin
                mismatched++;
                $display("FAIL ignore_start_idle: busy=%b done=%b out=%h N=%b, want 0 0 0f 1", busy, done, out, out_N);
            end
        end
    endtask

    task automatic test_abort();
        int lat;
        logic bok;
        logic [W+3:0] got;
        run_op(4'd0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, lat, bok, got);
        compared++;
        if (got !== {8'h46, 4'b0000}) begin
            mismatched++;
            $display("FAIL abort_pre_op: out=%h ZNHC=%b, want 46 0000", got[W+3:4], got[3:0]);
        end
        @(posedge clk);
        #1;
        alu_op = 4'd0;
        in_A   = 8'h0F;
        in_B   = 8'h01;
        start  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            compared++;
            if ({busy, done, out, out_Z, out_N, out_H, out_C} !== '0) begin
                mismatched++;
                $display("FAIL abort_in_reset[%0d]: busy=%b done=%b out=%h ZNHC=%b%b%b%b, want all 0",
                         i, busy, done, out, out_Z, out_N, out_H, out_C);
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (NIB + 2) begin
            @(posedge clk);
            #1;
            compared++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL abort_no_done: busy=%b done=%b, want 0 0", busy, done);
            end
        end
        run_op(4'd1, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, lat, bok, got);
        compared++;
        if (lat != NIB || bok !== 1'b1 || got !== {8'h00, 4'b1011}) begin
            mismatched++;
            $display("FAIL abort_recover: lat=%0d busy_ok=%b out=%h ZNHC=%b, want %0d 1 00 1011",
                     lat, bok, got[W+3:4], got[3:0], NIB);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        alu_op = 4'd0;
        in_A   = '0;
        in_B   = '0;
        in_C   = 1'b0;
        in_N   = 1'b0;
        in_H   = 1'b0;
        test_reset();
        test_directed();
        test_random(60, "random");
        test_back_to_back();
        test_ignore_start();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_serial.md
# alu_serial

Multi-cycle, nibble-serial arithmetic/logic unit for the CPU datapath. It computes WIDTH-bit results on a single 4-bit adder slice, one nibble per clock, LSB nibble first. It produces the full Z/N/H/C flag set used by the CPU flag register. It extends the combinational 4-bit ALU with parameterised width, a start/done handshake and half-carry/subtract flags.

## Interface
- WIDTH, 8, operand/result width in bits; a multiple of 4 and at least 4 (8 and 16 are used by the CPU).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- alu_op  in  4  0 add, 1 adc, 2 sub, 3 sbc, 4 and, 5 xor, 6 or, 7 cp, 8 daa (see Configuration); 9–15 illegal.
- in_A  in  WIDTH  operand A.
- in_B  in  WIDTH  operand B.
- in_C  in  1  carry/borrow in; used by adc, sbc and daa.
- in_N  in  1  prior N flag; used by daa only.
- in_H  in  1  prior H flag; used by daa only.
- busy  out  1  an operation is in progress.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- out  out  WIDTH  result.
- out_Z, out_N, out_H, out_C  out  1 each  zero, subtract, half-carry and carry/borrow flags.

## Operation
- FSM states:
  - IDLE: wait for start.
  - RUN: process nibble index i = 0 .. WIDTH/4-1.
  - DONE: one cycle, then back to IDLE.
- Transitions:
  - IDLE → RUN when start=1. The same edge latches in_A, in_B, alu_op, in_C, in_N and in_H, and sets i=0.
  - RUN → DONE on the edge that processes the last nibble.
  - DONE → IDLE unconditionally.
- Inputs are don't-care after the latch edge.
- Add/adc:
  - Each nibble computes A_i + B_i + c.
  - Initial c is 0 for add, in_C for adc.
  - c is the carry out of bit 3 of the previous nibble.
- Sub/sbc/cp:
  - Each nibble computes A_i + ~B_i + c.
  - Initial c is 1 for sub/cp, and !in_C for sbc.
  - Borrow = !carry.
- Flags:
  - C = final carry (add/adc), or final borrow (sub/sbc/cp).
  - H = carry (or borrow) out of bit 3 of nibble 0.
  - N = 1 for sub/sbc/cp/daa-with-in_N, otherwise 0.
  - Z = 1 iff every result nibble is 0; accumulate it as a running OR.
- cp: flags as for sub; out = latched A.
- and: bitwise; H=1, C=0, N=0.
- xor/or: bitwise; H=0, C=0, N=0.
- Illegal op: out = latched A; Z from A; N=H=C=0; timing as for a legal op.
- out and the flags are registered and hold their value until the next done.
- Reset values: state IDLE, busy 0, done 0, out 0, all flags 0.

## Timing
- Latency: start sampled at edge k; nibble i is processed at edge k+1+i.
- done=1 and results become valid after edge k+WIDTH/4.
- busy is 1 from edge k until the edge that asserts done; it is 0 while done=1.
- start while busy or done is ignored, and nothing is queued.
- Back-to-back operations: start may be asserted in the cycle after done (IDLE). Minimum period is WIDTH/4+2 cycles.
- rst during RUN or DONE: next state IDLE, all outputs return to reset values, no done pulse. rst wins over a simultaneous start.
- WIDTH=4 degenerates to a single RUN cycle and keeps the same handshake.

## Configuration
- ALU_SERIAL_DAA_EN defined: op 8 is decimal adjust of latched A (WIDTH=8 only).
  - Correction after add (in_N=0):
    - +0x06 if in_H or low nibble > 9.
    - +0x60 if in_C or A > 0x99; this sets C.
  - After sub (in_N=1): −0x06 if in_H, −0x60 if in_C.
  - Flags: H=0, N=in_N, Z from the result.
  - Latency is the same as for any other op.
- ALU_SERIAL_DAA_EN undefined: op 8 behaves as illegal. No DAA logic is synthesised.

## Test plan
- WIDTH=8, add 0x0F+0x01, in_C=1 → out 0x10, H=1, C=0, Z=0, N=0. done exactly 2 cycles after the start edge; busy high in between.
- add 0xFF+0x01 → out 0x00, Z=1, H=1, C=1. Then adc 0x00+0x00 with in_C=1 → 0x01, Z=0, C=0.
- sub 0x10−0x01 → 0x0F, N=1, H=1, C=0. sbc 0x00−0x00 with in_C=1 → 0xFF, N=1, H=1, C=1.
- cp 0x42 vs 0x42 → out 0x42, Z=1, N=1, C=0. and 0xF0&0x0F → 0x00, Z=1, H=1, C=0.
- Assert start at edge k, pulse rst at edge k+1, keep start high → no done pulse, all outputs 0, busy 0. Then drop rst and issue a new op → normal completion. start pulsed during busy is ignored.
- With ALU_SERIAL_DAA_EN: add 0x15+0x27 → 0x3C, H=0, C=0. Then daa with A=0x3C, in_N=0, in_H=0, in_C=0 → 0x42, C=0, Z=0. Without the macro, the same daa → out 0x3C, flags N=H=C=0.
